routing_table_prog: RTL and testbench
=====================================

# routing_table_prog

Programmable, parametrised successor to the fixed NI-target routing LUT. It maps a SOURCE_WD-bit source address to a PATH_WD-bit source route (first hop in LSBs, last hop in MSBs) from a run-time writable, directly indexed table of 2^SOURCE_WD entries with per-entry valid bits. Lookups use a registered valid/ready handshake and report hit/miss, and a saturating miss counter is provided. It sits inside the NI target, between response-packet header generation and the flit builder, and is programmed by the configuration port at boot or on topology change.

## Interface
- SOURCE_WD, 4, source-address width; table depth is 2^SOURCE_WD
- PATH_WD, 7, route width in bits
- MISS_CNT_WD, 8, miss counter width
- clk  in  1  clock; all state updates on rising edge
- rst_n  in  1  asynchronous active-low reset
- cfg_we  in  1  table write strobe
- cfg_addr  in  SOURCE_WD  entry index to write
- cfg_path  in  PATH_WD  route to store
- cfg_valid  in  1  1 installs the entry, 0 invalidates it (path still stored)
- cfg_clr_all  in  1  invalidates all entries
- lk_req_valid  in  1  lookup request valid
- lk_req_ready  out  1  lookup request accepted when valid&ready
- lk_addr  in  SOURCE_WD  source address to look up
- lk_resp_valid  out  1  response valid
- lk_resp_ready  in  1  downstream accepts response
- lk_path  out  PATH_WD  route; 0 on miss
- lk_hit  out  1  1 if the entry was valid
- miss_count  out  MISS_CNT_WD  saturating count of accepted missing lookups
- miss_clr  in  1  synchronous clear of miss_count

## Operation
- Reset (rst_n low, asynchronous): all entry paths are 0, all valid bits are 0, lk_resp_valid=0, lk_path=0, lk_hit=0, miss_count=0. After reset lk_req_ready=1.
- Table write: if cfg_we=1 and cfg_clr_all=0, entry[cfg_addr] takes {valid=cfg_valid, path=cfg_path} at the clock edge.
- cfg_clr_all=1 clears every valid bit and leaves stored paths untouched. A cfg_we in the same cycle is ignored.
- lk_req_ready = !lk_resp_valid | lk_resp_ready. This is combinational and gives a single-entry output register with full throughput.
- A lookup is accepted when lk_req_valid & lk_req_ready. At the next edge:
  - lk_resp_valid=1
  - lk_hit = entry[lk_addr].valid
  - lk_path = valid ? entry.path : 0
- Response hold: while lk_resp_valid & !lk_resp_ready, lk_path, lk_hit and lk_resp_valid stay stable and no new request is accepted.
- Response retire: when the response is taken (lk_resp_ready=1) and no new request is accepted, lk_resp_valid goes to 0 at the edge. lk_path and lk_hit keep their last values.
- Read-during-write: a lookup accepted in the same cycle as a write or clr_all affecting its entry returns the pre-update contents. Old-data semantics apply.
- Miss counter: increments by 1 on each accepted lookup that misses and saturates at 2^MISS_CNT_WD-1.
  - miss_clr sets it to 0.
  - If miss_clr and a miss increment coincide, the result is 0.
- lk_addr is always in range because the table is fully decoded; there is no out-of-range case.

## Timing
- Lookup latency is 1 cycle from acceptance to lk_resp_valid.
- Throughput is 1 lookup per cycle while lk_resp_ready=1.
- Write-to-lookup visibility: a write at edge N is seen by lookups accepted in cycle N+1 or later.
- miss_count updates at the edge that registers the missing response.
- No combinational path from lk_addr or cfg_* to any output. The only combinational output path is lk_resp_ready -> lk_req_ready.
- Reset asserted mid-operation drops lk_resp_valid immediately and discards any held response and all table contents.

## Test plan
- Program 0x3->0000001, 0x6->0000010, 0xd->0000011, 0x9->0011100, then look up 3,6,d,9,0 back-to-back with resp_ready=1 -> paths 0000001, 0000010, 0000011, 0011100, 0000000; hit=1,1,1,1,0; miss_count=1; one response per cycle.
- Backpressure: hold lk_resp_ready=0 for 3 cycles after a lookup of 0x6 with lk_req_valid held on 0xd -> lk_req_ready=0, lk_path=0000010 stable. On release the response retires and 0xd is accepted the same cycle, returning 0000011 the next cycle.
- Read-during-write: in the same cycle, look up 0x9 and write 0x9->1010101 -> response path 0011100; the next lookup of 0x9 returns 1010101.
- Invalidate and clear:
  - cfg_valid=0 write to 0x3, then look up 0x3 -> hit=0, path=0.
  - cfg_clr_all with cfg_we to 0x6 in the same cycle -> lookup of 0x6 returns hit=0.
- Saturation with MISS_CNT_WD=2: 5 misses -> miss_count=3. Then miss_clr coincident with a miss -> 0.
- Async reset mid-hold: assert rst_n=0 while lk_resp_valid=1 -> outputs go to 0 without a clock edge. After release, lookup of 0xd returns hit=0.

Source files
------------

// File: rtl/routing_table_prog_if.sv
// Purpose: bundles the config-write, lookup handshake and miss-counter signals of routing_table_prog.
// Latency: none, this is wiring only; the timing lives in routing_table_prog.
// Backpressure: lk_resp_ready flows toward the table, and lk_req_ready flows back to the requester.
interface routing_table_prog_if #(
   parameter int SOURCE_WD   = 4,
   parameter int PATH_WD     = 7,
   parameter int MISS_CNT_WD = 8
);
   // configuration port
   logic                   cfg_we;
   logic [SOURCE_WD-1:0]   cfg_addr;
   logic [PATH_WD-1:0]     cfg_path;
   logic                   cfg_valid;
   logic                   cfg_clr_all;
   // lookup request / response
   logic                   lk_req_valid;
   logic                   lk_req_ready;
   logic [SOURCE_WD-1:0]   lk_addr;
   logic                   lk_resp_valid;
   logic                   lk_resp_ready;
   logic [PATH_WD-1:0]     lk_path;
   logic                   lk_hit;
   // miss statistics
   logic [MISS_CNT_WD-1:0] miss_count;
   logic                   miss_clr;

   // requester / programmer side
   modport master (
      output cfg_we, cfg_addr, cfg_path, cfg_valid, cfg_clr_all,
      output lk_req_valid, lk_addr, lk_resp_ready, miss_clr,
      input  lk_req_ready, lk_resp_valid, lk_path, lk_hit, miss_count
   );

   // routing table side
   modport slave (
      input  cfg_we, cfg_addr, cfg_path, cfg_valid, cfg_clr_all,
      input  lk_req_valid, lk_addr, lk_resp_ready, miss_clr,
      output lk_req_ready, lk_resp_valid, lk_path, lk_hit, miss_count
   );
endinterface

// File: rtl/routing_table_prog.sv
// Purpose: run-time programmable source-address -> source-route table with valid bits and a miss counter.
// Latency: 1 cycle from lookup acceptance to lk_resp_valid; 1 lookup per cycle while lk_resp_ready=1.
// Backpressure: single output register; lk_req_ready = !lk_resp_valid | lk_resp_ready, and a held response stays stable.
module routing_table_prog #(
   parameter int SOURCE_WD   = 4,
   parameter int PATH_WD     = 7,
   parameter int MISS_CNT_WD = 8
) (
   input  logic                 clk,
   input  logic                 rst_n,
   routing_table_prog_if.slave  bus
);
   localparam int DEPTH = 1 << SOURCE_WD;
   localparam logic [MISS_CNT_WD-1:0] MISS_MAX = '1;

   // table storage
   logic [PATH_WD-1:0]     path_q [DEPTH];
   logic [PATH_WD-1:0]     path_d [DEPTH];
   logic [DEPTH-1:0]       valid_q, valid_d;

   // response register and statistics
   logic                   resp_valid_q, resp_valid_d;
   logic [PATH_WD-1:0]     lk_path_q, lk_path_d;
   logic                   lk_hit_q, lk_hit_d;
   logic [MISS_CNT_WD-1:0] miss_cnt_q, miss_cnt_d;

   logic                   req_ready;
   logic                   accept;
   logic                   entry_valid;
   logic [PATH_WD-1:0]     entry_path;

   // The output register can take a new lookup whenever it is empty or being drained this cycle.
   assign req_ready   = !resp_valid_q | bus.lk_resp_ready;
   assign accept      = bus.lk_req_valid & req_ready;
   // Reads use the registered table, so a same-cycle write is not visible (old-data semantics).
   assign entry_valid = valid_q[bus.lk_addr];
   assign entry_path  = path_q[bus.lk_addr];

   // Table update: clear-all wins over a coincident single-entry write, and it only drops valid bits.
   always_comb begin
      path_d  = path_q;
      valid_d = valid_q;
      if (bus.cfg_clr_all) begin
         valid_d = '0;
      end else if (bus.cfg_we) begin
         path_d[bus.cfg_addr]  = bus.cfg_path;
         valid_d[bus.cfg_addr] = bus.cfg_valid;
      end
   end

   // Response register: load on accept, retire on drain; path/hit keep their last values after retire.
   always_comb begin
      resp_valid_d = resp_valid_q;
      lk_path_d    = lk_path_q;
      lk_hit_d     = lk_hit_q;
      if (accept) begin
         resp_valid_d = 1'b1;
         lk_hit_d     = entry_valid;
         lk_path_d    = entry_valid ? entry_path : '0;
      end else if (bus.lk_resp_ready) begin
         resp_valid_d = 1'b0;
      end
   end

   // Miss counter: saturating increment per accepted miss; a clear overrides a coincident miss.
   always_comb begin
      miss_cnt_d = miss_cnt_q;
      if (bus.miss_clr) begin
         miss_cnt_d = '0;
      end else if (accept && !entry_valid && (miss_cnt_q != MISS_MAX)) begin
         miss_cnt_d = miss_cnt_q + 1'b1;
      end
   end

   // State registers; reset discards the table contents and any held response.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         path_q       <= '{default: '0};
         valid_q      <= '0;
         resp_valid_q <= 1'b0;
         lk_path_q    <= '0;
         lk_hit_q     <= 1'b0;
         miss_cnt_q   <= '0;
      end else begin
         path_q       <= path_d;
         valid_q      <= valid_d;
         resp_valid_q <= resp_valid_d;
         lk_path_q    <= lk_path_d;
         lk_hit_q     <= lk_hit_d;
         miss_cnt_q   <= miss_cnt_d;
      end
   end

   assign bus.lk_req_ready  = req_ready;
   assign bus.lk_resp_valid = resp_valid_q;
   assign bus.lk_path       = lk_path_q;
   assign bus.lk_hit        = lk_hit_q;
   assign bus.miss_count    = miss_cnt_q;
endmodule

// File: tb/tb_routing_table_prog.sv
// Purpose: checks routing_table_prog against a table/scoreboard model and hand-computed literals.
// Latency: expects responses one edge after acceptance.
// Backpressure: exercises held responses, same-cycle retire/accept and async reset during a hold.
module tb_routing_table_prog;
   localparam int SW = 4;
   localparam int PW = 7;
   localparam int CW = 2;
   localparam int CMAX = (1 << CW) - 1;

   logic clk;
   logic rst_n;
   int   checks = 0;
   int   errors = 0;

   routing_table_prog_if #(.SOURCE_WD(SW), .PATH_WD(PW), .MISS_CNT_WD(CW)) bus ();

   routing_table_prog #(.SOURCE_WD(SW), .PATH_WD(PW), .MISS_CNT_WD(CW)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
      end
   endtask

   // Behavioural model: a plain array for the table plus the visible response and counter.
   logic [PW-1:0] m_path [16];
   logic          m_valid [16];
   logic          m_rv;
   logic          m_hit;
   logic [PW-1:0] m_out;
   int            m_cnt;

   // Compare DUT outputs against the model each falling edge, then advance the model with the inputs
   // the next rising edge will sample.
   always @(negedge clk) begin
      if (!rst_n) begin
         for (int i = 0; i < 16; i++) begin
            m_path[i]  = '0;
            m_valid[i] = 1'b0;
         end
         m_rv  = 1'b0;
         m_hit = 1'b0;
         m_out = '0;
         m_cnt = 0;
         check("rst resp_valid", {31'd0, bus.lk_resp_valid}, 32'd0);
         check("rst lk_path", {25'd0, bus.lk_path}, 32'd0);
         check("rst miss_count", {30'd0, bus.miss_count}, 32'd0);
      end else begin
         logic acc;
         logic e;
         int   a;
         check("mdl resp_valid", {31'd0, bus.lk_resp_valid}, {31'd0, m_rv});
         check("mdl lk_path", {25'd0, bus.lk_path}, {25'd0, m_out});
         check("mdl lk_hit", {31'd0, bus.lk_hit}, {31'd0, m_hit});
         check("mdl miss_count", {30'd0, bus.miss_count}, m_cnt);
         check("mdl req_ready", {31'd0, bus.lk_req_ready}, {31'd0, (!m_rv || bus.lk_resp_ready)});
         acc = bus.lk_req_valid && (!m_rv || bus.lk_resp_ready);
         a   = int'(bus.lk_addr);
         e   = m_valid[a];
         if (acc) begin
            m_rv  = 1'b1;
            m_hit = e;
            m_out = e ? m_path[a] : '0;
         end else if (bus.lk_resp_ready) begin
            m_rv = 1'b0;
         end
         if (bus.miss_clr) m_cnt = 0;
         else if (acc && !e) m_cnt = (m_cnt == CMAX) ? CMAX : m_cnt + 1;
         if (bus.cfg_clr_all) begin
            for (int i = 0; i < 16; i++) m_valid[i] = 1'b0;
         end else if (bus.cfg_we) begin
            m_path[int'(bus.cfg_addr)]  = bus.cfg_path;
            m_valid[int'(bus.cfg_addr)] = bus.cfg_valid;
         end
      end
   end

   // Watchdog so the run always terminates.
   initial begin
      #100000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "timeout");
   end

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic wr(input logic [SW-1:0] a, input logic [PW-1:0] p, input logic v);
      bus.cfg_we    = 1'b1;
      bus.cfg_addr  = a;
      bus.cfg_path  = p;
      bus.cfg_valid = v;
      step();
      bus.cfg_we    = 1'b0;
   endtask

   task automatic expect_resp(input string name, input logic [PW-1:0] p, input logic h);
      check({name, " valid"}, {31'd0, bus.lk_resp_valid}, 32'd1);
      check({name, " path"}, {25'd0, bus.lk_path}, {25'd0, p});
      check({name, " hit"}, {31'd0, bus.lk_hit}, {31'd0, h});
   endtask

   initial begin
      rst_n             = 1'b0;
      bus.cfg_we        = 1'b0;
      bus.cfg_addr      = '0;
      bus.cfg_path      = '0;
      bus.cfg_valid     = 1'b0;
      bus.cfg_clr_all   = 1'b0;
      bus.lk_req_valid  = 1'b0;
      bus.lk_addr       = '0;
      bus.lk_resp_ready = 1'b1;
      bus.miss_clr      = 1'b0;
      step();
      step();
      check("reset req_ready", {31'd0, bus.lk_req_ready}, 32'd1);
      check("reset hit", {31'd0, bus.lk_hit}, 32'd0);
      rst_n = 1'b1;
      step();

      // Program and read back-to-back
      wr(4'h3, 7'b0000001, 1'b1);
      wr(4'h6, 7'b0000010, 1'b1);
      wr(4'hd, 7'b0000011, 1'b1);
      wr(4'h9, 7'b0011100, 1'b1);
      bus.lk_req_valid = 1'b1;
      bus.lk_addr = 4'h3; step(); expect_resp("lk3", 7'b0000001, 1'b1);
      bus.lk_addr = 4'h6; step(); expect_resp("lk6", 7'b0000010, 1'b1);
      bus.lk_addr = 4'hd; step(); expect_resp("lkd", 7'b0000011, 1'b1);
      bus.lk_addr = 4'h9; step(); expect_resp("lk9", 7'b0011100, 1'b1);
      bus.lk_addr = 4'h0; step(); expect_resp("lk0", 7'b0000000, 1'b0);
      check("miss after lk0", {30'd0, bus.miss_count}, 32'd1);
      bus.lk_req_valid = 1'b0;
      step();
      check("retired", {31'd0, bus.lk_resp_valid}, 32'd0);

      // Backpressure with a pending request
      bus.lk_req_valid = 1'b1;
      bus.lk_addr = 4'h6;
      step();
      bus.lk_resp_ready = 1'b0;
      bus.lk_addr = 4'hd;
      #1;
      check("bp req_ready", {31'd0, bus.lk_req_ready}, 32'd0);
      for (int i = 0; i < 3; i++) begin
         step();
         expect_resp("bp hold", 7'b0000010, 1'b1);
         check("bp hold req_ready", {31'd0, bus.lk_req_ready}, 32'd0);
      end
      bus.lk_resp_ready = 1'b1;
      #1;
      check("release req_ready", {31'd0, bus.lk_req_ready}, 32'd1);
      step();
      expect_resp("after release", 7'b0000011, 1'b1);
      bus.lk_req_valid = 1'b0;
      step();

      // Read during write returns old data
      bus.lk_req_valid = 1'b1;
      bus.lk_addr = 4'h9;
      wr(4'h9, 7'b1010101, 1'b1);
      expect_resp("rdw old", 7'b0011100, 1'b1);
      step();
      expect_resp("rdw new", 7'b1010101, 1'b1);
      bus.lk_req_valid = 1'b0;
      step();

      // Invalidate one entry, then clear-all with a coincident ignored write
      wr(4'h3, 7'b1111111, 1'b0);
      bus.lk_req_valid = 1'b1;
      bus.lk_addr = 4'h3;
      step();
      bus.lk_req_valid = 1'b0;
      expect_resp("invalidated", 7'b0000000, 1'b0);
      bus.cfg_clr_all = 1'b1;
      wr(4'h6, 7'b0010001, 1'b1);
      bus.cfg_clr_all = 1'b0;
      bus.lk_req_valid = 1'b1;
      bus.lk_addr = 4'h6;
      step();
      bus.lk_req_valid = 1'b0;
      expect_resp("clr_all", 7'b0000000, 1'b0);
      check("miss sat 3", {30'd0, bus.miss_count}, 32'd3);

      // Saturation and clear-vs-miss priority
      bus.miss_clr = 1'b1;
      step();
      bus.miss_clr = 1'b0;
      check("miss cleared", {30'd0, bus.miss_count}, 32'd0);
      bus.lk_req_valid = 1'b1;
      bus.lk_addr = 4'h0;
      for (int i = 0; i < 5; i++) step();
      check("miss saturated", {30'd0, bus.miss_count}, 32'd3);
      bus.miss_clr = 1'b1;
      step();
      bus.miss_clr = 1'b0;
      check("clr beats miss", {30'd0, bus.miss_count}, 32'd0);
      step();
      check("miss after clr", {30'd0, bus.miss_count}, 32'd1);
      bus.lk_req_valid = 1'b0;
      step();

      // Async reset while a response is held
      wr(4'hd, 7'b0000011, 1'b1);
      bus.lk_req_valid = 1'b1;
      bus.lk_addr = 4'hd;
      bus.lk_resp_ready = 1'b0;
      step();
      bus.lk_req_valid = 1'b0;
      expect_resp("pre reset", 7'b0000011, 1'b1);
      #2;
      rst_n = 1'b0;
      #1;
      check("async valid", {31'd0, bus.lk_resp_valid}, 32'd0);
      check("async path", {25'd0, bus.lk_path}, 32'd0);
      check("async hit", {31'd0, bus.lk_hit}, 32'd0);
      check("async req_ready", {31'd0, bus.lk_req_ready}, 32'd1);
      bus.lk_resp_ready = 1'b1;
      step();
      rst_n = 1'b1;
      step();
      bus.lk_req_valid = 1'b1;
      bus.lk_addr = 4'hd;
      step();
      bus.lk_req_valid = 1'b0;
      expect_resp("post reset d", 7'b0000000, 1'b0);
      step();
      step();

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
